apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- Upstream neighbour of the APB slave: converts a simple valid/ready command stream into APB3 SETUP/ACCESS transfers and returns a response stream.
- Sits between the bus-fabric/test-driver command source and any APB slave, one transfer in flight.
- Adds a wait-state timeout so a slave that never raises pready cannot hang the bus.

Parameters:
- ADDR_W, 32, width of cmd_addr/paddr
- DATA_W, 32, width of wdata/rdata buses
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles waiting for pready before abort; legal range 1..65535

Ports:
- clk  in  1  single clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (async, rst=1): state IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout all 0; timeout counter 0. Reset mid-transfer drops psel/penable immediately; no response is produced.
- All outputs are registered except cmd_ready, which is (state==IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch write/addr/wdata into pwrite/paddr/pwdata and go to SETUP. With cmd_valid=0, hold.
- SETUP (exactly 1 cycle): psel=1, penable=0. Next state is ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata stable; counter increments each cycle pready=0.
  - pready=1 sampled: capture rsp_rdata=(pwrite?0:prdata) and rsp_err=pslverr; set rsp_timeout=0; drop psel/penable; go to RESP.
  - Counter reaches TIMEOUT_CYCLES with pready=0: drop psel/penable; rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
  - pready and timeout in the same cycle: pready wins.
- RESP: rsp_valid=1, rsp payload stable; psel=0. On rsp_ready, go to IDLE and clear rsp_valid. Stalled rsp_ready holds RESP indefinitely with no new command accepted.
- Latency with a 1-wait-state slave (pready registered one cycle after penable): cmd handshake at cycle T, psel at T+1, penable at T+2, pready at T+3, rsp_valid at T+4. Minimum command-to-command spacing is 5 cycles with rsp_ready tied high.
- The counter clears on entry to SETUP; it is 16 bits wide.
- pready/pslverr/prdata are ignored outside ACCESS.

Decomposition:
- apb_pkg: apb_state_e enum (IDLE, SETUP, ACCESS, RESP), default ADDR_W/DATA_W localparams, TIMEOUT_W=16.
- One sub-module is natural: apb_wait_timer, a load/enable/expire counter parameterised by TIMEOUT_CYCLES, instantiated once.

Test Plan:
- Write 0x0000_0010 <= 0xDEAD_BEEF, slave with 1 wait state: psel at T+1, penable T+2, pwdata=0xDEADBEEF stable; rsp_valid at T+4 with rsp_err=0, rsp_rdata=0.
- Read 0x0000_0020, slave returns prdata=0x1234_5678 with pready: rsp_rdata=0x12345678, rsp_err=0, rsp_timeout=0.
- Slave asserts pslverr=1 with pready on a read: rsp_err=1, rsp_timeout=0.
- Slave never asserts pready, TIMEOUT_CYCLES=4: psel/penable drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held 0 for 10 cycles with cmd_valid=1: cmd_ready=0 throughout, rsp payload stable, no new psel; on release, next command is accepted the following cycle.
- Assert rst during ACCESS: psel/penable=0 in the same cycle (async), no rsp_valid; after deassert, a new write completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master slice.
//   apb_state_e : master FSM states (IDLE, SETUP, ACCESS, RESP)
//   APB_ADDR_W  : default address width
//   APB_DATA_W  : default data width
//   TIMEOUT_W   : width of the ACCESS-phase wait-state counter
// ---------------------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int TIMEOUT_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// ---------------------------------------------------------------------------
// apb_wait_timer
// Counts ACCESS-phase wait states and flags the cycle in which the limit of
// TIMEOUT_CYCLES waited cycles is reached.
// Ports:
//   clk    : clock, posedge
//   rst    : asynchronous active-high reset, clears the count
//   load   : clear the count (asserted when a transfer is launched)
//   enable : count this cycle (slave is inserting a wait state)
//   expire : this enabled cycle is the TIMEOUT_CYCLES-th wait state
// ---------------------------------------------------------------------------
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expire
);

    // Expiry is decided combinationally on the last enabled cycle, so the
    // comparison is against one less than the limit.
    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] count;

    // Wait-state counter: cleared on load, advanced on every wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = enable && (count == LAST_COUNT);

endmodule

// File: rtl/apb_master.sv
// ---------------------------------------------------------------------------
// apb_master
// Converts a valid/ready command stream into APB3 SETUP/ACCESS transfers and
// returns a response stream. One transfer in flight; a wait-state timeout
// aborts transfers whose slave never raises pready.
// Ports:
//   clk, rst                 : clock (posedge) and async active-high reset
//   cmd_valid/cmd_ready      : command handshake (cmd_ready = FSM in IDLE)
//   cmd_write/addr/wdata     : command payload
//   rsp_valid/rsp_ready      : response handshake
//   rsp_rdata/err/timeout    : response payload (rdata 0 for writes/timeouts)
//   psel/penable/pwrite      : APB control, registered
//   paddr/pwdata             : APB address and write data, registered
//   prdata/pready/pslverr    : APB slave returns, sampled only in ACCESS
// ---------------------------------------------------------------------------
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        state, state_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              timer_load, timer_enable, timer_expire;

    assign cmd_ready    = (state == IDLE);
    assign timer_load   = (state == IDLE) && cmd_valid;
    assign timer_enable = (state == ACCESS) && !pready;

    apb_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .enable(timer_enable),
        .expire(timer_expire)
    );

    // State and output registers. Every output except cmd_ready comes
    // straight from a flop, so a reset drops psel/penable immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    // Next-state and next-output logic. Registers hold by default; each
    // state only touches what changes on its exit. pready is checked before
    // the timer so a ready arriving on the expiry cycle still completes.
    always_comb begin
        state_d       = state;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if (timer_expire) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb_master.sv
// ---------------------------------------------------------------------------
// tb_apb_master
// Directed self-checking bench for apb_master (TIMEOUT_CYCLES = 4). The APB
// slave side is driven by hand to model a 1-wait-state slave, an erroring
// slave, a slave that never answers, and a zero-wait slave.
// ---------------------------------------------------------------------------
module tb_apb_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int errors = 0;
    int checks = 0;

    apb_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are changed and
    // outputs sampled there, well away from the edge itself.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic write,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = valid;
        cmd_write = write;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [31:0] held_rdata;

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b1;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

        // ---------------- reset state ----------------
        tick();
        tick();
        checkOutput("rst_psel",      psel,        0);
        checkOutput("rst_penable",   penable,     0);
        checkOutput("rst_rsp_valid", rsp_valid,   0);
        checkOutput("rst_paddr",     paddr,       0);
        checkOutput("rst_rdata",     rsp_rdata,   0);
        checkOutput("rst_timeout",   rsp_timeout, 0);
        checkOutput("rst_cmd_ready", cmd_ready,   1);
        rst = 1'b0;
        tick();

        // ---------------- write, 1 wait state ----------------
        $display("[TB] write 0x10 <= 0xDEADBEEF");
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        checkOutput("wr_cmd_ready", cmd_ready, 1);
        tick();                                   // T+1
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("wr_t1_psel",    psel,    1);
        checkOutput("wr_t1_penable", penable, 0);
        checkOutput("wr_t1_pwrite",  pwrite,  1);
        checkOutput("wr_t1_paddr",   paddr,   32'h0000_0010);
        checkOutput("wr_t1_pwdata",  pwdata,  32'hDEAD_BEEF);
        checkOutput("wr_t1_cmd_rdy", cmd_ready, 0);
        tick();                                   // T+2
        checkOutput("wr_t2_psel",    psel,    1);
        checkOutput("wr_t2_penable", penable, 1);
        checkOutput("wr_t2_pwdata",  pwdata,  32'hDEAD_BEEF);
        tick();                                   // T+3, slave now ready
        checkOutput("wr_t3_penable", penable, 1);
        checkOutput("wr_t3_rsp_vld", rsp_valid, 0);
        pready = 1'b1;
        prdata = 32'hAAAA_5555;                   // must not leak into a write response
        tick();                                   // T+4
        pready = 1'b0;
        checkOutput("wr_t4_rsp_vld", rsp_valid,   1);
        checkOutput("wr_t4_err",     rsp_err,     0);
        checkOutput("wr_t4_rdata",   rsp_rdata,   0);
        checkOutput("wr_t4_timeout", rsp_timeout, 0);
        checkOutput("wr_t4_psel",    psel,        0);
        checkOutput("wr_t4_penable", penable,     0);
        tick();
        checkOutput("wr_done_vld",   rsp_valid, 0);
        checkOutput("wr_done_rdy",   cmd_ready, 1);

        // ---------------- read 0x20 -> 0x12345678 ----------------
        $display("[TB] read 0x20");
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rd_pwrite", pwrite, 0);
        checkOutput("rd_paddr",  paddr,  32'h0000_0020);
        tick();
        tick();
        pready = 1'b1;
        prdata = 32'h1234_5678;
        tick();
        pready = 1'b0;
        prdata = 32'h0;
        checkOutput("rd_rsp_vld", rsp_valid,   1);
        checkOutput("rd_rdata",   rsp_rdata,   32'h1234_5678);
        checkOutput("rd_err",     rsp_err,     0);
        checkOutput("rd_timeout", rsp_timeout, 0);
        tick();

        // ---------------- read with pslverr, then stalled response ----------------
        $display("[TB] read 0x30 with slave error, response stalled");
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0030, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hCAFE_0001;
        tick();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
        checkOutput("err_rsp_vld", rsp_valid,   1);
        checkOutput("err_err",     rsp_err,     1);
        checkOutput("err_timeout", rsp_timeout, 0);
        checkOutput("err_rdata",   rsp_rdata,   32'hCAFE_0001);
        held_rdata = rsp_rdata;

        // next command waits while the response is held back
        applyStimulus(1'b1, 1'b0, 32'h0000_0040, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("stall_cmd_rdy", cmd_ready, 0);
            checkOutput("stall_psel",    psel,      0);
            checkOutput("stall_rsp_vld", rsp_valid, 1);
            checkOutput("stall_rdata",   rsp_rdata, 32'hCAFE_0001);
            checkOutput("stall_err",     rsp_err,   1);
        end
        rsp_ready = 1'b1;
        tick();
        checkOutput("rel_rsp_vld", rsp_valid, 0);
        checkOutput("rel_cmd_rdy", cmd_ready, 1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("rel_psel",  psel,  1);
        checkOutput("rel_paddr", paddr, 32'h0000_0040);

        // ---------------- timeout: slave never raises pready ----------------
        $display("[TB] read 0x40, slave silent");
        prdata = 32'hFFFF_FFFF;
        tick();                                   // ACCESS cycle 1
        checkOutput("to_acc1_penable", penable, 1);
        tick();                                   // ACCESS cycle 2
        tick();                                   // ACCESS cycle 3
        tick();                                   // ACCESS cycle 4
        checkOutput("to_acc4_psel",    psel,      1);
        checkOutput("to_acc4_penable", penable,   1);
        checkOutput("to_acc4_rsp_vld", rsp_valid, 0);
        tick();
        checkOutput("to_psel",     psel,        0);
        checkOutput("to_penable",  penable,     0);
        checkOutput("to_rsp_vld",  rsp_valid,   1);
        checkOutput("to_err",      rsp_err,     1);
        checkOutput("to_timeout",  rsp_timeout, 1);
        checkOutput("to_rdata",    rsp_rdata,   0);
        prdata = 32'h0;
        tick();
        checkOutput("to_done_rdy", cmd_ready, 1);

        // ---------------- reset during ACCESS ----------------
        $display("[TB] reset in ACCESS");
        applyStimulus(1'b1, 1'b1, 32'h0000_0080, 32'h1111_2222);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        checkOutput("ar_pre_penable", penable, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("ar_psel",    psel,      0);
        checkOutput("ar_penable", penable,   0);
        checkOutput("ar_rsp_vld", rsp_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkOutput("ar_after_vld", rsp_valid, 0);
        checkOutput("ar_after_rdy", cmd_ready, 1);

        // ---------------- write after reset, zero-wait slave ----------------
        $display("[TB] write 0x90 <= 0x55AA55AA after reset");
        applyStimulus(1'b1, 1'b1, 32'h0000_0090, 32'h55AA_55AA);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("pw_paddr",  paddr,  32'h0000_0090);
        checkOutput("pw_pwdata", pwdata, 32'h55AA_55AA);
        pready = 1'b1;                            // ignored in SETUP
        tick();
        checkOutput("pw_penable", penable, 1);
        tick();
        pready = 1'b0;
        checkOutput("pw_rsp_vld", rsp_valid,   1);
        checkOutput("pw_err",     rsp_err,     0);
        checkOutput("pw_timeout", rsp_timeout, 0);
        checkOutput("pw_rdata",   rsp_rdata,   0);
        tick();
        checkOutput("pw_done_rdy", cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
